// File: rtl/ac_pkg.sv
// Shared definitions for the AC sequencer.
//   ac_seq_state_t : sequencer FSM states
//   AC_CFG_*       : bit positions inside the 3-bit AC config word
package ac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } ac_seq_state_t;

    localparam int unsigned AC_CFG_ACC  = 2;
    localparam int unsigned AC_CFG_RELU = 1;
    localparam int unsigned AC_CFG_BN   = 0;

endpackage

// File: rtl/ac_seq_dly.sv
// Two-stage delay line that aligns AC strobes with 1-cycle memory read data.
//   clk, rst        : clock, asynchronous active-high reset
//   rd_en           : psum read strobe (read cycle t)
//   bn_en           : BN read strobe (read cycle t)
//   last            : the psum read at t produces a final AC output
//   in_en           : rd_en delayed by one cycle
//   bn_param_in_en  : bn_en delayed by one cycle
//   f               : final-output strobe, two cycles after a qualifying read
module ac_seq_dly (
    input  logic clk,
    input  logic rst,
    input  logic rd_en,
    input  logic bn_en,
    input  logic last,
    output logic in_en,
    output logic bn_param_in_en,
    output logic f
);

    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_en          <= 1'b0;
            bn_param_in_en <= 1'b0;
            last_q         <= 1'b0;
            f              <= 1'b0;
        end else begin
            in_en          <= rd_en;
            bn_param_in_en <= bn_en;
            last_q         <= rd_en & last;
            f              <= last_q;
        end
    end

endmodule

// File: rtl/ac_seq_ctrl.sv
// Sequencer for one accumulation/BN/ReLU unit: per channel it loads BN
// parameters, streams the channel's partial sums and flags the final output.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : run request pulse (ignored while busy)
//   cfg_num_psum      : partial sums per channel (latched at start)
//   cfg_num_ch        : channels per run (latched at start)
//   cfg_mode          : {acc_en, relu_en, bn_en} (latched at start)
//   psum_rd_en/addr   : psum buffer read port
//   bn_rd_en/addr     : BN memory read port (address = current channel)
//   ac_in_en, ac_F, ac_bn_param_in_en, ac_config_bits : AC control
//   busy, done, ch_idx: run status
module ac_seq_ctrl #(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned CH_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_num_psum,
    input  logic [CH_WIDTH-1:0]   cfg_num_ch,
    input  logic [2:0]            cfg_mode,
    output logic                  psum_rd_en,
    output logic [ADDR_WIDTH-1:0] psum_rd_addr,
    output logic                  bn_rd_en,
    output logic [CH_WIDTH-1:0]   bn_rd_addr,
    output logic                  ac_in_en,
    output logic                  ac_F,
    output logic                  ac_bn_param_in_en,
    output logic [2:0]            ac_config_bits,
    output logic                  busy,
    output logic                  done,
    output logic [CH_WIDTH-1:0]   ch_idx
);

    import ac_pkg::*;

    ac_seq_state_t         state_q, state_n;
    logic [CH_WIDTH-1:0]   ch_q, ch_n;
    logic [CNT_WIDTH-1:0]  beat_q, beat_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [CNT_WIDTH-1:0]  num_psum_q, num_psum_n;
    logic [CH_WIDTH-1:0]   num_ch_q, num_ch_n;
    logic [2:0]            mode_q, mode_n;
    logic                  busy_n, done_n;
    logic                  last_q, last_n;

    // Strobes and counters are registered from the next-state values so the
    // outputs seen in a cycle describe the state being executed in that cycle.
    always_comb begin
        state_n    = state_q;
        ch_n       = ch_q;
        beat_n     = beat_q;
        addr_n     = addr_q;
        num_psum_n = num_psum_q;
        num_ch_n   = num_ch_q;
        mode_n     = mode_q;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_num_psum != '0 && cfg_num_ch != '0) begin
                        state_n    = LOAD;
                        num_psum_n = cfg_num_psum;
                        num_ch_n   = cfg_num_ch;
                        mode_n     = cfg_mode;
                        ch_n       = '0;
                        addr_n     = '0;
                        busy_n     = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_n = STREAM;
                beat_n  = '0;
            end
            STREAM: begin
                addr_n = addr_q + ADDR_WIDTH'(1);
                beat_n = beat_q + CNT_WIDTH'(1);
                if (beat_q == num_psum_q - CNT_WIDTH'(1)) begin
                    if (ch_q < num_ch_q - CH_WIDTH'(1)) begin
                        ch_n    = ch_q + CH_WIDTH'(1);
                        state_n = LOAD;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Once the first delay stage is empty, the final F strobe is
                // in its last stage this cycle, so the run ends here.
                if (!ac_in_en) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        last_n = (state_n == STREAM) &&
                 (!mode_n[AC_CFG_ACC] || beat_n == num_psum_n - CNT_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            num_psum_q <= '0;
            num_ch_q   <= '0;
            mode_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            psum_rd_en <= 1'b0;
            bn_rd_en   <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            ch_q       <= ch_n;
            beat_q     <= beat_n;
            addr_q     <= addr_n;
            num_psum_q <= num_psum_n;
            num_ch_q   <= num_ch_n;
            mode_q     <= mode_n;
            busy       <= busy_n;
            done       <= done_n;
            psum_rd_en <= (state_n == STREAM);
            bn_rd_en   <= (state_n == LOAD);
            last_q     <= last_n;
        end
    end

    assign psum_rd_addr   = addr_q;
    assign bn_rd_addr     = ch_q;
    assign ch_idx         = ch_q;
    assign ac_config_bits = mode_q;

    ac_seq_dly u_dly (
        .clk            (clk),
        .rst            (rst),
        .rd_en          (psum_rd_en),
        .bn_en          (bn_rd_en),
        .last           (last_q),
        .in_en          (ac_in_en),
        .bn_param_in_en (ac_bn_param_in_en),
        .f              (ac_F)
    );

endmodule

// File: tb/tb_ac_seq_ctrl.sv
module tb_ac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_num_psum = '0;
    logic [7:0]  cfg_num_ch = '0;
    logic [2:0]  cfg_mode = '0;
    logic        psum_rd_en;
    logic [15:0] psum_rd_addr;
    logic        bn_rd_en;
    logic [7:0]  bn_rd_addr;
    logic        ac_in_en;
    logic        ac_F;
    logic        ac_bn_param_in_en;
    logic [2:0]  ac_config_bits;
    logic        busy;
    logic        done;
    logic [7:0]  ch_idx;

    int checks = 0;
    int failures = 0;
    logic [2:0] cfg_model = '0;
    int ch_model = 0;

    ac_seq_ctrl #(.CNT_WIDTH(8), .CH_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_num_psum      (cfg_num_psum),
        .cfg_num_ch        (cfg_num_ch),
        .cfg_mode          (cfg_mode),
        .psum_rd_en        (psum_rd_en),
        .psum_rd_addr      (psum_rd_addr),
        .bn_rd_en          (bn_rd_en),
        .bn_rd_addr        (bn_rd_addr),
        .ac_in_en          (ac_in_en),
        .ac_F              (ac_F),
        .ac_bn_param_in_en (ac_bn_param_in_en),
        .ac_config_bits    (ac_config_bits),
        .busy              (busy),
        .done              (done),
        .ch_idx            (ch_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference schedule: cycle k after the start cycle. Each channel spends
    // one cycle on the BN load followed by np psum reads.
    function automatic bit is_psum(input int k, input int np, input int nch);
        int per = np + 1;
        if (np == 0 || nch == 0 || k < 1 || k > nch * per) return 1'b0;
        return ((k - 1) % per) != 0;
    endfunction

    function automatic bit is_bn(input int k, input int np, input int nch);
        int per = np + 1;
        if (np == 0 || nch == 0 || k < 1 || k > nch * per) return 1'b0;
        return ((k - 1) % per) == 0;
    endfunction

    function automatic int beat_of(input int k, input int np);
        return ((k - 1) % (np + 1)) - 1;
    endfunction

    function automatic int chan_of(input int k, input int np);
        return (k - 1) / (np + 1);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psum_en"}, 32'(psum_rd_en), 32'd0);
        chk({tag, "_psum_addr"}, 32'(psum_rd_addr), 32'd0);
        chk({tag, "_bn_en"}, 32'(bn_rd_en), 32'd0);
        chk({tag, "_bn_addr"}, 32'(bn_rd_addr), 32'd0);
        chk({tag, "_in_en"}, 32'(ac_in_en), 32'd0);
        chk({tag, "_F"}, 32'(ac_F), 32'd0);
        chk({tag, "_bnp_en"}, 32'(ac_bn_param_in_en), 32'd0);
        chk({tag, "_cfg"}, 32'(ac_config_bits), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ch"}, 32'(ch_idx), 32'd0);
    endtask

    // Called at #1 after a rising edge; start is high for the current cycle.
    task automatic run(input int np, input int nch, input logic [2:0] mode,
                       input int restart_k, input int abort_k);
        bit valid;
        int per, tt;
        bit e_f;
        valid = (np != 0) && (nch != 0);
        per = np + 1;
        tt = valid ? nch * per : 0;
        start = 1'b1;
        cfg_num_psum = 8'(np);
        cfg_num_ch = 8'(nch);
        cfg_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_num_psum = 8'($urandom);
        cfg_num_ch = 8'($urandom);
        cfg_mode = 3'($urandom);
        if (valid) cfg_model = mode;
        for (int k = 1; k <= tt + 4; k++) begin
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk_all_zero("abort");
                @(posedge clk); #1;
                rst = 1'b0;
                cfg_model = '0;
                ch_model = 0;
                for (int j = 0; j < 4; j++) begin
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    @(posedge clk); #1;
                end
                return;
            end
            chk("psum_rd_en", 32'(psum_rd_en), 32'(is_psum(k, np, nch)));
            if (is_psum(k, np, nch))
                chk("psum_rd_addr", 32'(psum_rd_addr),
                    32'((chan_of(k, np) * np + beat_of(k, np)) % 65536));
            chk("bn_rd_en", 32'(bn_rd_en), 32'(is_bn(k, np, nch)));
            if (is_bn(k, np, nch))
                chk("bn_rd_addr", 32'(bn_rd_addr), 32'(chan_of(k, np)));
            chk("ac_in_en", 32'(ac_in_en), 32'(is_psum(k - 1, np, nch)));
            chk("ac_bn_param_in_en", 32'(ac_bn_param_in_en), 32'(is_bn(k - 1, np, nch)));
            e_f = is_psum(k - 2, np, nch) && (!mode[2] || beat_of(k - 2, np) == np - 1);
            chk("ac_F", 32'(ac_F), 32'(e_f));
            chk("busy", 32'(busy), 32'(valid && k <= tt + 2));
            chk("done", 32'(done), 32'(valid ? (k == tt + 3) : (k == 1)));
            chk("ch_idx", 32'(ch_idx),
                32'(valid ? ((k <= tt) ? chan_of(k, np) : nch - 1) : ch_model));
            chk("ac_config_bits", 32'(ac_config_bits), 32'(cfg_model));
            start = (k == restart_k);
            if (start) begin
                cfg_num_psum = 8'($urandom_range(1, 9));
                cfg_num_ch = 8'($urandom_range(1, 9));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (valid) ch_model = nch - 1;
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        run(4, 1, 3'b101, -1, -1);
        run(3, 3, 3'b111, -1, -1);
        run(2, 1, 3'b001, -1, -1);
        run(0, 5, 3'b111, -1, -1);
        run(5, 0, 3'b100, -1, -1);
        run(3, 2, 3'b110, 3, -1);
        run(2, 2, 3'b101, 8, -1);
        run(4, 3, 3'b111, 8, -1);
        run(4, 3, 3'b101, -1, 8);
        run(2, 2, 3'b100, -1, -1);
        run(1, 4, 3'b111, -1, -1);

        for (int r = 0; r < 8; r++) begin
            int np, nch;
            np = int'($urandom_range(1, 7));
            nch = int'($urandom_range(1, 5));
            run(np, nch, 3'($urandom), ($urandom_range(0, 1) == 1) ? 2 : -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
